// File: rtl/tl_arb_pkg.sv
// Shared widths, opcodes, FSM states and beat helpers for the TL-UL client arbiter.
package tl_arb_pkg;

    localparam int unsigned ADDR_W   = 28;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MASK_W   = DATA_W / 8;
    localparam int unsigned CSRC_W   = 4;
    localparam int unsigned MSRC_W   = CSRC_W + 1;
    localparam int unsigned SIZE_W   = 4;
    localparam int unsigned MAX_SIZE = 6;
    localparam int unsigned BEAT_W   = MAX_SIZE - 2;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_BURST = 2'd2
    } arb_st_e;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [2:0]        param;
        logic [SIZE_W-1:0] size;
        logic [CSRC_W-1:0] source;
        logic [ADDR_W-1:0] address;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] data;
        logic              corrupt;
    } a_chan_t;

    // Number of data beats carried by a message of lg2 size `size`.
    function automatic int unsigned beats(input logic [SIZE_W-1:0] size);
        if (size <= SIZE_W'(2)) begin
            return 32'd1;
        end
        return 32'd1 << (size - SIZE_W'(2));
    endfunction

    // Only Puts carry data on A, so only they span several beats.
    function automatic logic is_multi(input logic [2:0] opcode, input logic [SIZE_W-1:0] size);
        return ((opcode == PUT_FULL) || (opcode == PUT_PARTIAL)) && (size > SIZE_W'(2));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin select; a held grant overrides arbitration.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic rr,
    input  logic lock,
    input  logic gnt,
    output logic sel_c
);

    // Lone requester wins, contention goes to the priority client.
    always_comb begin
        sel_c = rr;
        if (lock) begin
            sel_c = gnt;
        end else if (req0 && !req1) begin
            sel_c = 1'b0;
        end else if (req1 && !req0) begin
            sel_c = 1'b1;
        end
    end

endmodule

// File: rtl/tl_client_arbiter.sv
// Shares one TL-UL master port between two clients; A arbitrated, D routed by source MSB.
module tl_client_arbiter
    import tl_arb_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                in0_a_valid,
    output logic                in0_a_ready,
    input  logic [2:0]          in0_a_bits_opcode,
    input  logic [2:0]          in0_a_bits_param,
    input  logic [SIZE_W-1:0]   in0_a_bits_size,
    input  logic [CSRC_W-1:0]   in0_a_bits_source,
    input  logic [ADDR_W-1:0]   in0_a_bits_address,
    input  logic [MASK_W-1:0]   in0_a_bits_mask,
    input  logic [DATA_W-1:0]   in0_a_bits_data,
    input  logic                in0_a_bits_corrupt,
    input  logic                in0_d_ready,
    output logic                in0_d_valid,
    output logic [2:0]          in0_d_bits_opcode,
    output logic [1:0]          in0_d_bits_param,
    output logic [SIZE_W-1:0]   in0_d_bits_size,
    output logic [CSRC_W-1:0]   in0_d_bits_source,
    output logic                in0_d_bits_sink,
    output logic                in0_d_bits_denied,
    output logic [DATA_W-1:0]   in0_d_bits_data,
    output logic                in0_d_bits_corrupt,
    input  logic                in1_a_valid,
    output logic                in1_a_ready,
    input  logic [2:0]          in1_a_bits_opcode,
    input  logic [2:0]          in1_a_bits_param,
    input  logic [SIZE_W-1:0]   in1_a_bits_size,
    input  logic [CSRC_W-1:0]   in1_a_bits_source,
    input  logic [ADDR_W-1:0]   in1_a_bits_address,
    input  logic [MASK_W-1:0]   in1_a_bits_mask,
    input  logic [DATA_W-1:0]   in1_a_bits_data,
    input  logic                in1_a_bits_corrupt,
    input  logic                in1_d_ready,
    output logic                in1_d_valid,
    output logic [2:0]          in1_d_bits_opcode,
    output logic [1:0]          in1_d_bits_param,
    output logic [SIZE_W-1:0]   in1_d_bits_size,
    output logic [CSRC_W-1:0]   in1_d_bits_source,
    output logic                in1_d_bits_sink,
    output logic                in1_d_bits_denied,
    output logic [DATA_W-1:0]   in1_d_bits_data,
    output logic                in1_d_bits_corrupt,
    output logic                out_a_valid,
    input  logic                out_a_ready,
    output logic [2:0]          out_a_bits_opcode,
    output logic [2:0]          out_a_bits_param,
    output logic [SIZE_W-1:0]   out_a_bits_size,
    output logic [MSRC_W-1:0]   out_a_bits_source,
    output logic [ADDR_W-1:0]   out_a_bits_address,
    output logic [MASK_W-1:0]   out_a_bits_mask,
    output logic [DATA_W-1:0]   out_a_bits_data,
    output logic                out_a_bits_corrupt,
    input  logic                out_d_valid,
    output logic                out_d_ready,
    input  logic [2:0]          out_d_bits_opcode,
    input  logic [1:0]          out_d_bits_param,
    input  logic [SIZE_W-1:0]   out_d_bits_size,
    input  logic [MSRC_W-1:0]   out_d_bits_source,
    input  logic                out_d_bits_sink,
    input  logic                out_d_bits_denied,
    input  logic [DATA_W-1:0]   out_d_bits_data,
    input  logic                out_d_bits_corrupt
);

    arb_st_e           st_q, st_d;
    logic              gnt_q, gnt_d;
    logic              rr_q, rr_d;
    logic [BEAT_W-1:0] beats_left_q, beats_left_d;

    logic    sel;
    logic    sel_valid;
    logic    fire;
    logic    d_tgt;
    a_chan_t a0, a1, a_sel;

    assign a0 = '{opcode: in0_a_bits_opcode, param: in0_a_bits_param, size: in0_a_bits_size,
                  source: in0_a_bits_source, address: in0_a_bits_address, mask: in0_a_bits_mask,
                  data: in0_a_bits_data, corrupt: in0_a_bits_corrupt};
    assign a1 = '{opcode: in1_a_bits_opcode, param: in1_a_bits_param, size: in1_a_bits_size,
                  source: in1_a_bits_source, address: in1_a_bits_address, mask: in1_a_bits_mask,
                  data: in1_a_bits_data, corrupt: in1_a_bits_corrupt};

    rr_arb2 u_rr_arb2 (
        .req0  (in0_a_valid),
        .req1  (in1_a_valid),
        .rr    (rr_q),
        .lock  (st_q != ST_IDLE),
        .gnt   (gnt_q),
        .sel_c (sel)
    );

    // A-channel mux; handshakes are squashed while reset is held.
    always_comb begin
        a_sel              = sel ? a1 : a0;
        sel_valid          = sel ? in1_a_valid : in0_a_valid;
        out_a_valid        = reset & sel_valid;
        in0_a_ready        = reset & ~sel & out_a_ready;
        in1_a_ready        = reset & sel & out_a_ready;
        fire               = out_a_valid & out_a_ready;
        out_a_bits_opcode  = a_sel.opcode;
        out_a_bits_param   = a_sel.param;
        out_a_bits_size    = a_sel.size;
        out_a_bits_source  = {sel, a_sel.source};
        out_a_bits_address = a_sel.address;
        out_a_bits_mask    = a_sel.mask;
        out_a_bits_data    = a_sel.data;
        out_a_bits_corrupt = a_sel.corrupt;
    end

    // Grant lock: hold an unaccepted message, lock multi-beat Puts, rotate priority per message.
    always_comb begin
        st_d         = st_q;
        gnt_d        = gnt_q;
        rr_d         = rr_q;
        beats_left_d = beats_left_q;
        unique case (st_q)
            ST_IDLE, ST_HOLD: begin
                if (fire) begin
                    if (is_multi(a_sel.opcode, a_sel.size)) begin
                        st_d         = ST_BURST;
                        gnt_d        = sel;
                        beats_left_d = BEAT_W'(beats(a_sel.size) - 32'd1);
                    end else begin
                        st_d = ST_IDLE;
                        rr_d = ~sel;
                    end
                end else if (out_a_valid) begin
                    st_d  = ST_HOLD;
                    gnt_d = sel;
                end
            end
            ST_BURST: begin
                if (fire) begin
                    beats_left_d = beats_left_q - BEAT_W'(1);
                    if (beats_left_q == BEAT_W'(1)) begin
                        st_d = ST_IDLE;
                        rr_d = ~gnt_q;
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // Arbiter state register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            st_q         <= ST_IDLE;
            gnt_q        <= 1'b0;
            rr_q         <= 1'b0;
            beats_left_q <= '0;
        end else begin
            st_q         <= st_d;
            gnt_q        <= gnt_d;
            rr_q         <= rr_d;
            beats_left_q <= beats_left_d;
        end
    end

    // D-channel routing by the client bit in the master source; payload is broadcast.
    always_comb begin
        d_tgt              = out_d_bits_source[CSRC_W];
        in0_d_valid        = reset & ~d_tgt & out_d_valid;
        in1_d_valid        = reset & d_tgt & out_d_valid;
        out_d_ready        = reset & (d_tgt ? in1_d_ready : in0_d_ready);
        in0_d_bits_opcode  = out_d_bits_opcode;
        in0_d_bits_param   = out_d_bits_param;
        in0_d_bits_size    = out_d_bits_size;
        in0_d_bits_source  = out_d_bits_source[CSRC_W-1:0];
        in0_d_bits_sink    = out_d_bits_sink;
        in0_d_bits_denied  = out_d_bits_denied;
        in0_d_bits_data    = out_d_bits_data;
        in0_d_bits_corrupt = out_d_bits_corrupt;
        in1_d_bits_opcode  = out_d_bits_opcode;
        in1_d_bits_param   = out_d_bits_param;
        in1_d_bits_size    = out_d_bits_size;
        in1_d_bits_source  = out_d_bits_source[CSRC_W-1:0];
        in1_d_bits_sink    = out_d_bits_sink;
        in1_d_bits_denied  = out_d_bits_denied;
        in1_d_bits_data    = out_d_bits_data;
        in1_d_bits_corrupt = out_d_bits_corrupt;
    end

endmodule

// File: tb/tb_tl_client_arbiter.sv
// Directed bench for tl_client_arbiter with a message-level reference model.
module tb_tl_client_arbiter;
    import tl_arb_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        a_valid [2];
    logic        a_ready [2];
    logic [2:0]  a_op    [2];
    logic [2:0]  a_par   [2];
    logic [3:0]  a_size  [2];
    logic [3:0]  a_src   [2];
    logic [27:0] a_addr  [2];
    logic [3:0]  a_mask  [2];
    logic [31:0] a_data  [2];
    logic        a_corr  [2];
    logic        d_ready [2];
    logic        d_valid [2];
    logic [2:0]  d_op    [2];
    logic [1:0]  d_par   [2];
    logic [3:0]  d_size  [2];
    logic [3:0]  d_src   [2];
    logic        d_sink  [2];
    logic        d_den   [2];
    logic [31:0] d_data  [2];
    logic        d_corr  [2];

    logic        out_a_valid, out_a_ready;
    logic [2:0]  out_a_bits_opcode, out_a_bits_param;
    logic [3:0]  out_a_bits_size, out_a_bits_mask;
    logic [4:0]  out_a_bits_source;
    logic [27:0] out_a_bits_address;
    logic [31:0] out_a_bits_data;
    logic        out_a_bits_corrupt;
    logic        out_d_valid, out_d_ready;
    logic [2:0]  od_op;
    logic [1:0]  od_par;
    logic [3:0]  od_size;
    logic [4:0]  od_src;
    logic        od_sink, od_den, od_corr;
    logic [31:0] od_data;

    tl_client_arbiter dut (
        .clock(clock), .reset(reset),
        .in0_a_valid(a_valid[0]), .in0_a_ready(a_ready[0]),
        .in0_a_bits_opcode(a_op[0]), .in0_a_bits_param(a_par[0]), .in0_a_bits_size(a_size[0]),
        .in0_a_bits_source(a_src[0]), .in0_a_bits_address(a_addr[0]), .in0_a_bits_mask(a_mask[0]),
        .in0_a_bits_data(a_data[0]), .in0_a_bits_corrupt(a_corr[0]),
        .in0_d_ready(d_ready[0]), .in0_d_valid(d_valid[0]),
        .in0_d_bits_opcode(d_op[0]), .in0_d_bits_param(d_par[0]), .in0_d_bits_size(d_size[0]),
        .in0_d_bits_source(d_src[0]), .in0_d_bits_sink(d_sink[0]), .in0_d_bits_denied(d_den[0]),
        .in0_d_bits_data(d_data[0]), .in0_d_bits_corrupt(d_corr[0]),
        .in1_a_valid(a_valid[1]), .in1_a_ready(a_ready[1]),
        .in1_a_bits_opcode(a_op[1]), .in1_a_bits_param(a_par[1]), .in1_a_bits_size(a_size[1]),
        .in1_a_bits_source(a_src[1]), .in1_a_bits_address(a_addr[1]), .in1_a_bits_mask(a_mask[1]),
        .in1_a_bits_data(a_data[1]), .in1_a_bits_corrupt(a_corr[1]),
        .in1_d_ready(d_ready[1]), .in1_d_valid(d_valid[1]),
        .in1_d_bits_opcode(d_op[1]), .in1_d_bits_param(d_par[1]), .in1_d_bits_size(d_size[1]),
        .in1_d_bits_source(d_src[1]), .in1_d_bits_sink(d_sink[1]), .in1_d_bits_denied(d_den[1]),
        .in1_d_bits_data(d_data[1]), .in1_d_bits_corrupt(d_corr[1]),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
        .out_a_bits_opcode(out_a_bits_opcode), .out_a_bits_param(out_a_bits_param),
        .out_a_bits_size(out_a_bits_size), .out_a_bits_source(out_a_bits_source),
        .out_a_bits_address(out_a_bits_address), .out_a_bits_mask(out_a_bits_mask),
        .out_a_bits_data(out_a_bits_data), .out_a_bits_corrupt(out_a_bits_corrupt),
        .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
        .out_d_bits_opcode(od_op), .out_d_bits_param(od_par), .out_d_bits_size(od_size),
        .out_d_bits_source(od_src), .out_d_bits_sink(od_sink), .out_d_bits_denied(od_den),
        .out_d_bits_data(od_data), .out_d_bits_corrupt(od_corr)
    );

    int vectors = 0;
    int fails   = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Message-level model: who owns the link, whether a burst is under way, beats remaining.
    bit m_lock, m_started, m_owner, m_prio;
    int m_rem;
    bit n_lock, n_started, n_owner, n_prio;
    int n_rem;
    bit m_sel, m_fire, m_t;
    int m_nb;

    function automatic int msg_beats(input logic [2:0] op, input logic [3:0] sz);
        if ((op == 3'd0 || op == 3'd1) && sz > 4'd2) return 2 ** (int'(sz) - 2);
        return 1;
    endfunction

    initial begin
        m_lock = 0; m_started = 0; m_owner = 0; m_prio = 0; m_rem = 0;
        n_lock = 0; n_started = 0; n_owner = 0; n_prio = 0; n_rem = 0;
    end

    // Compare every cycle at the falling edge, then work out the model's next state.
    always @(negedge clock) begin
        if (chk_en) begin
            n_lock = m_lock; n_started = m_started; n_owner = m_owner; n_prio = m_prio; n_rem = m_rem;
            if (!reset) begin
                chk("rst_out_a_valid", 64'(out_a_valid), 64'd0);
                chk("rst_a_ready", 64'({a_ready[0], a_ready[1]}), 64'd0);
                chk("rst_out_d_ready", 64'(out_d_ready), 64'd0);
                chk("rst_d_valid", 64'({d_valid[0], d_valid[1]}), 64'd0);
                n_lock = 0; n_started = 0; n_owner = 0; n_prio = 0; n_rem = 0;
            end else begin
                if (m_lock) m_sel = m_owner;
                else if (a_valid[0] && !a_valid[1]) m_sel = 1'b0;
                else if (a_valid[1] && !a_valid[0]) m_sel = 1'b1;
                else m_sel = m_prio;
                chk("out_a_valid", 64'(out_a_valid), 64'(a_valid[m_sel]));
                chk("in0_a_ready", 64'(a_ready[0]), 64'(!m_sel && out_a_ready));
                chk("in1_a_ready", 64'(a_ready[1]), 64'(m_sel && out_a_ready));
                chk("out_a_source", 64'(out_a_bits_source), 64'({m_sel, a_src[m_sel]}));
                chk("out_a_address", 64'(out_a_bits_address), 64'(a_addr[m_sel]));
                chk("out_a_data", 64'(out_a_bits_data), 64'(a_data[m_sel]));
                chk("out_a_ctl", 64'({out_a_bits_opcode, out_a_bits_param, out_a_bits_size, out_a_bits_mask, out_a_bits_corrupt}),
                    64'({a_op[m_sel], a_par[m_sel], a_size[m_sel], a_mask[m_sel], a_corr[m_sel]}));
                m_fire = a_valid[m_sel] && out_a_ready;
                if (m_fire) begin
                    if (m_lock && m_started) begin
                        n_rem = m_rem - 1;
                        if (n_rem == 0) begin n_lock = 0; n_started = 0; n_prio = !m_owner; end
                    end else begin
                        m_nb = msg_beats(a_op[m_sel], a_size[m_sel]);
                        if (m_nb > 1) begin
                            n_lock = 1; n_started = 1; n_owner = m_sel; n_rem = m_nb - 1;
                        end else begin
                            n_lock = 0; n_started = 0; n_prio = !m_sel;
                        end
                    end
                end else if (!m_lock && a_valid[m_sel]) begin
                    n_lock = 1; n_started = 0; n_owner = m_sel;
                end
                m_t = od_src[4];
                chk("d_valid_tgt", 64'(d_valid[m_t]), 64'(out_d_valid));
                chk("d_valid_other", 64'(d_valid[!m_t]), 64'd0);
                chk("out_d_ready", 64'(out_d_ready), 64'(d_ready[m_t]));
                chk("d_source", 64'(d_src[m_t]), 64'(od_src[3:0]));
                chk("d_data", 64'(d_data[m_t]), 64'(od_data));
                chk("d_ctl", 64'({d_op[m_t], d_par[m_t], d_size[m_t], d_sink[m_t], d_den[m_t], d_corr[m_t]}),
                    64'({od_op, od_par, od_size, od_sink, od_den, od_corr}));
            end
        end
    end

    always @(posedge clock) begin
        m_lock    <= n_lock;
        m_started <= n_started;
        m_owner   <= n_owner;
        m_prio    <= n_prio;
        m_rem     <= n_rem;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put_a(input int k, input logic v, input logic [2:0] op, input logic [3:0] sz,
                         input logic [3:0] src, input logic [27:0] addr, input logic [31:0] dat);
        a_valid[k] = v; a_op[k] = op; a_par[k] = 3'd0; a_size[k] = sz; a_src[k] = src;
        a_addr[k] = addr; a_mask[k] = 4'hf; a_data[k] = dat; a_corr[k] = 1'b0;
    endtask

    task automatic put_d(input logic v, input logic [2:0] op, input logic [4:0] src, input logic [31:0] dat);
        out_d_valid = v; od_op = op; od_par = 2'd0; od_size = 4'd2; od_src = src;
        od_sink = 1'b0; od_den = 1'b0; od_data = dat; od_corr = 1'b0;
    endtask

    task automatic idle_a();
        put_a(0, 1'b0, GET, 4'd2, 4'd0, 28'h0, 32'h0);
        put_a(1, 1'b0, GET, 4'd2, 4'd0, 28'h0, 32'h0);
    endtask

    task automatic chk_owner(input string nm, input bit exp_owner);
        logic [4:0] s;
        s = out_a_bits_source;
        chk(nm, 64'(s[4]), 64'(exp_owner));
        chk({nm, "_valid"}, 64'(out_a_valid), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    bit exp_rr[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit exp_burst[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        idle_a();
        put_d(1'b0, ACCESS_ACK, 5'd0, 32'h0);
        d_ready[0] = 1'b0; d_ready[1] = 1'b0;
        out_a_ready = 1'b0;

        // Reset: valids present but every handshake squashed.
        reset = 1'b0;
        put_a(0, 1'b1, GET, 4'd2, 4'd3, 28'h0000100, 32'h0);
        put_d(1'b1, ACCESS_ACK, 5'd0, 32'h0);
        d_ready[0] = 1'b1; out_a_ready = 1'b1;
        tick();
        chk_en = 1'b1;
        chk("reset_a_valid", 64'(out_a_valid), 64'd0);
        chk("reset_in0_a_ready", 64'(a_ready[0]), 64'd0);
        chk("reset_in0_d_valid", 64'(d_valid[0]), 64'd0);
        tick();
        reset = 1'b1;
        put_d(1'b0, ACCESS_ACK, 5'd0, 32'h0);
        d_ready[0] = 1'b0;

        // Lone in0 Get passes straight through.
        #1;
        chk("t1_valid", 64'(out_a_valid), 64'd1);
        chk("t1_source", 64'(out_a_bits_source), 64'h03);
        chk("t1_in0_ready", 64'(a_ready[0]), 64'd1);
        chk("t1_in1_ready", 64'(a_ready[1]), 64'd0);
        tick();
        idle_a();

        // Both valid single-beat Gets alternate 0,1,0,1.
        do_reset();
        put_a(0, 1'b1, GET, 4'd2, 4'd1, 28'h0000200, 32'h0);
        put_a(1, 1'b1, GET, 4'd2, 4'd2, 28'h0000300, 32'h0);
        out_a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_owner($sformatf("t2_owner%0d", i), exp_rr[i]);
            tick();
        end
        idle_a();

        // 4-beat PutFull from in0 holds the link, then in1.
        do_reset();
        put_a(0, 1'b1, PUT_FULL, 4'd4, 4'd5, 28'h0000400, 32'hA0A0A0A0);
        put_a(1, 1'b1, GET, 4'd2, 4'd6, 28'h0000500, 32'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_owner($sformatf("t3_owner%0d", i), exp_burst[i]);
            tick();
        end
        idle_a();

        // Stalled in0 keeps the grant although in1 has priority.
        do_reset();
        put_a(0, 1'b1, GET, 4'd2, 4'd0, 28'h0000600, 32'h0);
        tick();
        put_a(0, 1'b1, GET, 4'd2, 4'd7, 28'h0000ABC, 32'h0);
        out_a_ready = 1'b0;
        #1;
        chk_owner("t4_hold0", 1'b0);
        tick();
        put_a(1, 1'b1, GET, 4'd2, 4'd8, 28'h0000DEF, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk_owner($sformatf("t4_hold%0d", i + 1), 1'b0);
            chk($sformatf("t4_addr%0d", i + 1), 64'(out_a_bits_address), 64'h0000ABC);
            tick();
        end
        out_a_ready = 1'b1;
        #1;
        chk_owner("t4_fire", 1'b0);
        chk("t4_in0_ready", 64'(a_ready[0]), 64'd1);
        tick();
        #1;
        chk_owner("t4_next", 1'b1);
        tick();
        idle_a();

        // D routing by source MSB, concurrent with A traffic.
        put_a(0, 1'b1, GET, 4'd2, 4'd9, 28'h0000700, 32'h0);
        put_d(1'b1, ACCESS_ACK_DATA, 5'b1_0010, 32'h12345678);
        d_ready[0] = 1'b1; d_ready[1] = 1'b1;
        #1;
        chk("t5_in1_d_valid", 64'(d_valid[1]), 64'd1);
        chk("t5_in1_d_source", 64'(d_src[1]), 64'd2);
        chk("t5_in0_d_valid", 64'(d_valid[0]), 64'd0);
        chk("t5_out_d_ready", 64'(out_d_ready), 64'd1);
        tick();
        d_ready[1] = 1'b0;
        #1;
        chk("t5_out_d_ready_low", 64'(out_d_ready), 64'd0);
        tick();
        put_d(1'b1, ACCESS_ACK, 5'b0_0111, 32'h0);
        #1;
        chk("t5_in0_d_valid", 64'(d_valid[0]), 64'd1);
        chk("t5_in0_d_source", 64'(d_src[0]), 64'd7);
        tick();
        put_d(1'b0, ACCESS_ACK, 5'd0, 32'h0);
        idle_a();

        // Reset in beat 2 of an in0 burst aborts it and clears priority.
        do_reset();
        put_a(0, 1'b1, GET, 4'd2, 4'd1, 28'h0000800, 32'h0);
        tick();
        put_a(0, 1'b1, PUT_FULL, 4'd4, 4'd2, 28'h0000900, 32'hB0B0B0B0);
        tick();
        reset = 1'b0;
        put_a(1, 1'b1, GET, 4'd2, 4'd3, 28'h0000A00, 32'h0);
        put_d(1'b1, ACCESS_ACK, 5'b1_0001, 32'h0);
        #1;
        chk("t6_rst_a_valid", 64'(out_a_valid), 64'd0);
        chk("t6_rst_a_ready", 64'({a_ready[0], a_ready[1]}), 64'd0);
        chk("t6_rst_d", 64'({out_d_ready, d_valid[0], d_valid[1]}), 64'd0);
        tick();
        reset = 1'b1;
        put_d(1'b0, ACCESS_ACK, 5'd0, 32'h0);
        put_a(0, 1'b1, GET, 4'd2, 4'd4, 28'h0000B00, 32'h0);
        #1;
        chk_owner("t6_after0", 1'b0);
        tick();
        #1;
        chk_owner("t6_after1", 1'b1);
        chk("t6_in1_ready", 64'(a_ready[1]), 64'd1);
        tick();
        idle_a();

        // Mixed traffic under a throttled master; checked by the model only.
        do_reset();
        for (int i = 0; i < 48; i++) begin
            put_a(0, 1'b1, (i % 8 < 4) ? GET : PUT_PARTIAL, (i % 8 < 4) ? 4'd6 : 4'd3,
                  4'(i), 28'(i * 16), 32'(i * 3));
            put_a(1, (i % 5) != 4, PUT_FULL, 4'd6, 4'(15 - i), 28'(i * 32), 32'(i * 7));
            out_a_ready = (i % 3) != 2;
            put_d((i % 2) == 0, ACCESS_ACK_DATA, 5'(i * 5), 32'(i * 11));
            d_ready[0] = (i % 4) != 1;
            d_ready[1] = (i % 3) != 0;
            tick();
        end
        idle_a();
        put_d(1'b0, ACCESS_ACK, 5'd0, 32'h0);
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
